// File: rtl/sc_muxn_pkg.sv
// Shared types for the N-channel registered selector: FSM state and mode encodings.
// Pure definitions; no logic, no latency, no flow control.
package sc_muxn_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A dwell of one still needs a one-bit counter to keep the port widths legal.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/sc_muxn_dwellcnt.sv
// Dwell counter: counts 0..NUMBER_DWELL-1, terminal count is combinational from the register.
// Clear wins over enable; no backpressure, advances on every enabled edge.
module sc_muxn_dwellcnt
  import sc_muxn_pkg::*;
#(
  parameter int NUMBER_DWELL = 4,
  parameter int CNT_W        = cnt_width(NUMBER_DWELL)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUMBER_DWELL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == LP_LAST);
  assign o_tc = w_tc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_muxn.sv
// N-channel registered selector, manual or round-robin scan; z follows channel register one edge later.
// Hold freezes all state and drops valid; no other backpressure.
module sc_muxn
  import sc_muxn_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_CHANNELS  = 4,
  parameter int NUMBER_SELWIDTH  = $clog2(NUMBER_CHANNELS),
  parameter int NUMBER_DWELL     = 4
) (
  input  logic                                         SC_MUXN_CLOCK_50,
  input  logic                                         SC_MUXN_RESET_InHigh,
  input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0]  SC_MUXN_data_InBUS,
  input  logic [NUMBER_SELWIDTH-1:0]                   SC_MUXN_select_InBUS,
  input  logic                                         SC_MUXN_load_In,
  input  logic                                         SC_MUXN_mode_In,
  input  logic                                         SC_MUXN_hold_In,
  output logic [NUMBER_DATAWIDTH-1:0]                  SC_MUXN_z_Out,
  output logic [NUMBER_SELWIDTH-1:0]                   SC_MUXN_channel_Out,
  output logic                                         SC_MUXN_valid_Out,
  output logic                                         SC_MUXN_wrap_Out,
  output logic                                         SC_MUXN_selErr_Out
);

  localparam int SW = NUMBER_SELWIDTH;
  // One extra bit so a power-of-two channel count is representable in the range check.
  localparam logic [SW:0]   LP_NCH  = (SW + 1)'(NUMBER_CHANNELS);
  localparam logic [SW-1:0] LP_LAST = SW'(NUMBER_CHANNELS - 1);

  state_t                      r_state;
  logic [SW-1:0]               r_channel;
  logic [NUMBER_DATAWIDTH-1:0] r_z;
  logic                        r_valid;
  logic                        r_wrap;
  logic                        r_selerr;

  state_t                      w_state_nxt;
  logic                        w_sel_ok;
  logic                        w_cnt_clr;
  logic                        w_cnt_en;
  logic                        w_cnt_tc;
  logic [SW-1:0]               w_ch_nxt;
  logic                        w_wrap_nxt;
  logic                        w_selerr_nxt;
  logic [NUMBER_DATAWIDTH-1:0] w_z_sel;

  assign w_z_sel = SC_MUXN_data_InBUS[int'(r_channel)*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];

  sc_muxn_dwellcnt #(
    .NUMBER_DWELL (NUMBER_DWELL)
  ) u_dwellcnt (
    .i_clk (SC_MUXN_CLOCK_50),
    .i_rst (SC_MUXN_RESET_InHigh),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_cnt_tc)
  );

  always_ff @(posedge SC_MUXN_CLOCK_50) begin
    if (SC_MUXN_RESET_InHigh) begin
      r_state <= ST_MANUAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!SC_MUXN_hold_In) begin
      w_state_nxt = (SC_MUXN_mode_In == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    end
  end

  // Behaviour is decided by the state held before this edge, so a mode change
  // takes effect one edge later with the counter starting from zero.
  always_comb begin
    w_sel_ok     = ({1'b0, SC_MUXN_select_InBUS} < LP_NCH);
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    w_ch_nxt     = r_channel;
    w_wrap_nxt   = 1'b0;
    w_selerr_nxt = 1'b0;
    if (!SC_MUXN_hold_In) begin
      if (SC_MUXN_load_In) begin
        if (w_sel_ok) begin
          w_ch_nxt  = SC_MUXN_select_InBUS;
          w_cnt_clr = 1'b1;
        end else begin
          w_selerr_nxt = 1'b1;
        end
      end else if (r_state == ST_SCAN) begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          if (r_channel == LP_LAST) begin
            w_ch_nxt   = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_ch_nxt = r_channel + 1'b1;
          end
        end
      end else begin
        w_cnt_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge SC_MUXN_CLOCK_50) begin
    if (SC_MUXN_RESET_InHigh) begin
      r_channel <= '0;
      r_z       <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
      r_selerr  <= 1'b0;
    end else if (SC_MUXN_hold_In) begin
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_selerr <= 1'b0;
    end else begin
      r_channel <= w_ch_nxt;
      r_z       <= w_z_sel;
      r_valid   <= 1'b1;
      r_wrap    <= w_wrap_nxt;
      r_selerr  <= w_selerr_nxt;
    end
  end

  assign SC_MUXN_z_Out       = r_z;
  assign SC_MUXN_channel_Out = r_channel;
  assign SC_MUXN_valid_Out   = r_valid;
  assign SC_MUXN_wrap_Out    = r_wrap;
  assign SC_MUXN_selErr_Out  = r_selerr;

endmodule

// File: tb/tb_sc_muxn.sv
// Bench for sc_muxn with five channels, dwell four: directed table, scan/hold/collision sequences, random run.
// Expected values come from constants and a modulo-arithmetic reference model.
module tb_sc_muxn;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int SW = 3;
  localparam int D  = 4;

  logic           clk = 1'b0;
  logic           rst, load, mode, hold;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] data_bus;
  logic [W-1:0]   data_arr [N];
  logic [W-1:0]   z;
  logic [SW-1:0]  ch;
  logic           valid, wrap, selerr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_ch, m_cnt, m_scan, m_z, m_v, m_w, m_e;

  always #5 clk = ~clk;

  always_comb begin
    data_bus = '0;
    for (int i = 0; i < N; i++) data_bus[i*W +: W] = data_arr[i];
  end

  sc_muxn #(
    .NUMBER_DATAWIDTH (W),
    .NUMBER_CHANNELS  (N),
    .NUMBER_SELWIDTH  (SW),
    .NUMBER_DWELL     (D)
  ) dut (
    .SC_MUXN_CLOCK_50     (clk),
    .SC_MUXN_RESET_InHigh (rst),
    .SC_MUXN_data_InBUS   (data_bus),
    .SC_MUXN_select_InBUS (sel),
    .SC_MUXN_load_In      (load),
    .SC_MUXN_mode_In      (mode),
    .SC_MUXN_hold_In      (hold),
    .SC_MUXN_z_Out        (z),
    .SC_MUXN_channel_Out  (ch),
    .SC_MUXN_valid_Out    (valid),
    .SC_MUXN_wrap_Out     (wrap),
    .SC_MUXN_selErr_Out   (selerr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int zn;
    if (rst) begin
      m_ch = 0; m_cnt = 0; m_scan = 0; m_z = 0; m_v = 0; m_w = 0; m_e = 0;
    end else if (hold) begin
      m_v = 0; m_w = 0; m_e = 0;
    end else begin
      zn  = int'(data_arr[m_ch]);
      m_w = 0;
      m_e = 0;
      if (load) begin
        if (int'(sel) < N) begin
          m_ch  = int'(sel);
          m_cnt = 0;
        end else begin
          m_e = 1;
        end
      end else if (m_scan != 0) begin
        m_cnt = (m_cnt + 1) % D;
        if (m_cnt == 0) begin
          if (m_ch == N - 1) m_w = 1;
          m_ch = (m_ch + 1) % N;
        end
      end else begin
        m_cnt = 0;
      end
      m_scan = int'(mode);
      m_z    = zn;
      m_v    = 1;
    end
  endtask

  task automatic check_model();
    chk("model_z",      int'(z),      m_z);
    chk("model_ch",     int'(ch),     m_ch);
    chk("model_valid",  int'(valid),  m_v);
    chk("model_wrap",   int'(wrap),   m_w);
    chk("model_selerr", int'(selerr), m_e);
  endtask

  task automatic step(input logic r, input logic l, input int s, input logic m, input logic h);
    rst  = r;
    load = l;
    sel  = SW'(s);
    mode = m;
    hold = h;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic rst, load, mode, hold;
    int   sel;
    int   e_ch, e_z, e_v, e_w, e_e;
  } vec_t;

  vec_t tbl [11];
  int   wraps;

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; hold = 1'b0; sel = '0;
    data_arr[0] = 8'h11; data_arr[1] = 8'h22; data_arr[2] = 8'h33;
    data_arr[3] = 8'h44; data_arr[4] = 8'h55;

    //           rst   load  mode  hold  sel  ch  z      v  w  e
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   0, 0,     0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3,   0, 0,     0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2,   2, 8'h11, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   2, 8'h33, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6,   2, 8'h33, 1, 0, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   2, 8'h33, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,   2, 8'h33, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4,   4, 8'h33, 1, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   4, 8'h55, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1,   4, 8'h55, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   4, 8'h55, 1, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst  = tbl[i].rst;
      load = tbl[i].load;
      mode = tbl[i].mode;
      hold = tbl[i].hold;
      sel  = SW'(tbl[i].sel);
      @(posedge clk);
      model_edge();
      #1;
      chk("tbl_ch",     int'(ch),     tbl[i].e_ch);
      chk("tbl_z",      int'(z),      tbl[i].e_z);
      chk("tbl_valid",  int'(valid),  tbl[i].e_v);
      chk("tbl_wrap",   int'(wrap),   tbl[i].e_w);
      chk("tbl_selerr", int'(selerr), tbl[i].e_e);
    end

    // Scan from channel 0: first channel gets the extra manual-state edge, wrap at edges 21 and 41.
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    wraps = 0;
    for (int i = 1; i <= 41; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      wraps += int'(wrap);
      if (i == 1)  chk("scan_z_first", int'(z), 8'h11);
      if (i == 5)  chk("scan_ch1_at5", int'(ch), 1);
      if (i == 6)  chk("scan_z_ch1", int'(z), 8'h22);
      if (i == 20) chk("scan_ch4_at20", int'(ch), 4);
      if (i == 21) begin
        chk("scan_wrap_at21", int'(wrap), 1);
        chk("scan_ch0_at21", int'(ch), 0);
      end
    end
    chk("scan_wrap_count", wraps, 2);

    // Hold at channel 1, counter 2, for five edges.
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("hold_pre_ch", int'(ch), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 0, 1'b1, 1'b1);
      chk("hold_ch", int'(ch), 1);
      chk("hold_z", int'(z), 8'h22);
      chk("hold_valid", int'(valid), 0);
    end
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("hold_rel_ch1", int'(ch), 1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("hold_rel_ch2", int'(ch), 2);

    // Load lands on the same edge as terminal count and wrap: load wins, no wrap pulse.
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3, 1'b1, 1'b0);
    chk("coll_ch", int'(ch), 3);
    chk("coll_wrap", int'(wrap), 0);
    for (int j = 1; j <= 4; j++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("coll_dwell_ch", int'(ch), (j < 4) ? 3 : 4);
    end

    // Reset mid-scan with hold and load asserted.
    step(1'b1, 1'b1, 2, 1'b1, 1'b1);
    chk("rst_hold_ch", int'(ch), 0);
    chk("rst_hold_z", int'(z), 0);

    // Random traffic against the model.
    mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, l, m, h;
      if ($urandom_range(0, 2) == 0) data_arr[$urandom_range(0, N-1)] = W'($urandom);
      r = ($urandom_range(0, 59) == 0);
      h = ($urandom_range(0, 5) == 0);
      l = ($urandom_range(0, 4) == 0);
      m = ($urandom_range(0, 24) == 0) ? ~mode : mode;
      step(r, l, int'($urandom_range(0, 7)), m, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
